count_checker: RTL and testbench

Synchronous receiver-side checker for the 4-bit up/down count stream produced by the team's counter blocks. Each enabled cycle it samples `count_in` and `updown` and verifies that the sample is exactly one step from the previous sample in the indicated direction, modulo 2^WIDTH. It acquires lock after a run of good steps and reports every break in the sequence while locked. It sits at the consuming end of a counter output, as a self-check monitor or as a sequence-integrity guard in front of downstream logic.

---
 rtl/count_pkg.sv | 13 +
 rtl/count_checker_step_predict.sv | 16 +
 rtl/count_checker.sv | 112 +++++++++++
 tb/tb_count_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared types and direction encoding for the counter blocks and their checker.
package count_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } chk_state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_checker_step_predict.sv
// Combinational prediction of the next count value from the last sample and the step direction.
module step_predict
   import count_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] last_count,
   input  logic             updown,
   output logic [WIDTH-1:0] expected
);

   // Natural modulo-2^WIDTH wrap makes 15->0 and 0->15 legal steps.
   assign expected = (updown == DIR_DOWN) ? last_count - WIDTH'(1)
                                          : last_count + WIDTH'(1);

endmodule

// File: rtl/count_checker.sv
// Up/down count stream checker: acquires lock after LOCK_CNT good steps, reports breaks while locked.
// Optional COUNT_CHECKER_STICKY_EN adds err_sticky, set on the first reported error.
module count_checker
   import count_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] count_in,
   input  logic             updown,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] last_count,
   output logic [1:0]       dbg_state
`ifdef COUNT_CHECKER_STICKY_EN
   ,
   output logic             err_sticky
`endif
);

   localparam int GW = $clog2(LOCK_CNT + 1);

   chk_state_t       r_state;
   logic [GW-1:0]    r_good_cnt;
   logic             r_locked;
   logic             r_err_pulse;
   logic [ERR_W-1:0] r_err_count;
   logic [WIDTH-1:0] r_last_count;
   logic             r_err_sticky;

   logic [WIDTH-1:0] w_expected;
   logic             w_match;
   logic [GW-1:0]    w_good_next;

   step_predict #(.WIDTH(WIDTH)) u_predict (
      .last_count (r_last_count),
      .updown     (updown),
      .expected   (w_expected)
   );

   assign w_match     = (count_in == w_expected);
   assign w_good_next = r_good_cnt + GW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_good_cnt   <= '0;
         r_locked     <= 1'b0;
         r_err_pulse  <= 1'b0;
         r_err_count  <= '0;
         r_last_count <= '0;
         r_err_sticky <= 1'b0;
      end else begin
         r_err_pulse <= 1'b0;
         if (en) begin
            // Always resync on the latest sample, even a bad one.
            r_last_count <= count_in;
            case (r_state)
               IDLE: begin
                  r_good_cnt <= '0;
                  r_state    <= ACQUIRE;
               end
               ACQUIRE: begin
                  if (w_match) begin
                     r_good_cnt <= w_good_next;
                     if (w_good_next == GW'(LOCK_CNT)) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                     end
                  end else begin
                     r_good_cnt <= '0;
                  end
               end
               LOCKED: begin
                  if (!w_match) begin
                     r_err_pulse  <= 1'b1;
                     r_err_sticky <= 1'b1;
                     if (r_err_count != '1)
                        r_err_count <= r_err_count + ERR_W'(1);
                     r_good_cnt   <= '0;
                     r_state      <= ACQUIRE;
                     r_locked     <= 1'b0;
                  end
               end
               default: begin
                  r_state  <= IDLE;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

   assign locked     = r_locked;
   assign err_pulse  = r_err_pulse;
   assign err_count  = r_err_count;
   assign last_count = r_last_count;
   assign dbg_state  = r_state;

`ifdef COUNT_CHECKER_STICKY_EN
   assign err_sticky = r_err_sticky;
`else
   logic w_sticky_unused;
   assign w_sticky_unused = r_err_sticky;
`endif

endmodule

// File: tb/tb_count_checker.sv
// Randomized and directed bench for count_checker against a sequence-rule reference model.
module tb_count_checker;
   import count_pkg::*;

   localparam int WIDTH    = 4;
   localparam int LOCK_CNT = 3;
   localparam int ERR_W    = 8;
   localparam int MODN     = 1 << WIDTH;
   localparam int ERR_MAX  = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic [WIDTH-1:0] count_in = '0;
   logic             updown = DIR_UP;
   logic             locked;
   logic             err_pulse;
   logic [ERR_W-1:0] err_count;
   logic [WIDTH-1:0] last_count;
   logic [1:0]       dbg_state;
`ifdef COUNT_CHECKER_STICKY_EN
   logic             err_sticky;
`endif

   count_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .count_in   (count_in),
      .updown     (updown),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_count  (err_count),
      .last_count (last_count),
      .dbg_state  (dbg_state)
`ifdef COUNT_CHECKER_STICKY_EN
      ,
      .err_sticky (err_sticky)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // A stream is "in sequence" when each sample is one step from the previous
   // one (mod 2^WIDTH) in the direction given with that sample.
   bit m_have_prev;
   int m_prev;
   int m_run;
   bit m_locked;
   int m_err;
   bit m_pulse;
   bit m_sticky;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void model_reset();
      m_have_prev = 0; m_prev = 0; m_run = 0; m_locked = 0;
      m_err = 0; m_pulse = 0; m_sticky = 0;
   endfunction

   function automatic void model_sample(bit e, int v, bit d);
      bit ok;
      int nxt;
      m_pulse = 0;
      if (!e) return;
      if (m_have_prev) begin
         nxt = (m_prev + (d ? MODN - 1 : 1)) % MODN;
         ok  = (v == nxt);
         if (m_locked) begin
            if (!ok) begin
               m_pulse  = 1;
               m_sticky = 1;
               m_err    = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
               m_locked = 0;
               m_run    = 0;
            end
         end else if (ok) begin
            m_run++;
            if (m_run == LOCK_CNT) m_locked = 1;
         end else begin
            m_run = 0;
         end
      end else begin
         m_have_prev = 1;
         m_run       = 0;
      end
      m_prev = v;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      int exp_state;
      exp_state = !m_have_prev ? int'(IDLE) : (m_locked ? int'(LOCKED) : int'(ACQUIRE));
      chk("locked",     int'(locked),     int'(m_locked));
      chk("err_pulse",  int'(err_pulse),  int'(m_pulse));
      chk("err_count",  int'(err_count),  m_err);
      chk("last_count", int'(last_count), m_prev);
      chk("state",      int'(dbg_state),  exp_state);
`ifdef COUNT_CHECKER_STICKY_EN
      chk("err_sticky", int'(err_sticky), int'(m_sticky));
`endif
   endtask

   // ---------------- driver ----------------
   // Called just after a falling edge; drives, lets the rising edge sample,
   // then compares on the next falling edge.
   task automatic cycle(input bit e, input int v, input bit d);
      en       = e;
      count_in = WIDTH'(v);
      updown   = d;
      model_sample(e, v, d);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic samp(input int v, input bit d);
      cycle(1'b1, v % MODN, d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      #1;
      model_reset();
      chk("rst_locked",    int'(locked),     0);
      chk("rst_err_pulse", int'(err_pulse),  0);
      chk("rst_err_count", int'(err_count),  0);
      chk("rst_last",      int'(last_count), 0);
`ifdef COUNT_CHECKER_STICKY_EN
      chk("rst_sticky",    int'(err_sticky), 0);
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int gen;
      bit d;
      int a;
      model_reset();
      @(negedge clk);
      do_reset();
      compare_all();

      // Clean up-count from reset: lock on the 4th sample.
      for (int v = 0; v <= 2; v++) samp(v, DIR_UP);
      chk("lit_not_locked_yet", int'(locked), 0);
      samp(3, DIR_UP);
      chk("lit_locked_after_3", int'(locked), 1);
      samp(4, DIR_UP);
      chk("lit_err_zero", int'(err_count), 0);

      // Up-wrap 15 -> 0 keeps lock.
      for (int v = 5; v <= 17; v++) samp(v, DIR_UP);
      chk("lit_wrap_up_locked", int'(locked), 1);

      // Down through 0 -> 15 to 3, then break with 7.
      for (int v = 16; v >= 3; v--) samp(v, DIR_DOWN);
      chk("lit_wrap_down_locked", int'(locked), 1);
      samp(7, DIR_DOWN);
      chk("lit_err_pulse", int'(err_pulse), 1);
      chk("lit_err_count1", int'(err_count), 1);
      chk("lit_unlocked", int'(locked), 0);
      samp(6, DIR_DOWN);
      chk("lit_pulse_one_cycle", int'(err_pulse), 0);
      samp(5, DIR_DOWN);
      samp(4, DIR_DOWN);
      chk("lit_relocked", int'(locked), 1);

      // Direction reversals are judged per step.
      samp(3, DIR_DOWN); samp(4, DIR_UP); samp(5, DIR_UP);
      samp(4, DIR_DOWN); samp(3, DIR_DOWN);
      chk("lit_reversal_locked", int'(locked), 1);
      chk("lit_reversal_err", int'(err_count), 1);

      // Gap with garbage, resume with the correct next value.
      for (int i = 0; i < 10; i++) cycle(1'b0, $urandom_range(0, MODN - 1), 1'($urandom_range(0, 1)));
      chk("lit_gap_last", int'(last_count), 3);
      samp(2, DIR_DOWN);
      chk("lit_gap_locked", int'(locked), 1);

      // Second error, relock, then reset while locked.
      samp(9, DIR_DOWN);
      samp(8, DIR_DOWN); samp(7, DIR_DOWN); samp(6, DIR_DOWN);
      chk("lit_err_count2", int'(err_count), 2);
      chk("lit_locked_before_rst", int'(locked), 1);
      do_reset();
      for (int v = 0; v <= 4; v++) samp(v, DIR_UP);
      chk("lit_relock_after_rst", int'(locked), 1);

      // Randomized stream: mostly legal steps, random direction, some breaks and gaps.
      gen = 4;
      for (int i = 0; i < 1500; i++) begin
         d = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) begin
            cycle(1'b0, $urandom_range(0, MODN - 1), d);
         end else if ($urandom_range(0, 19) == 0) begin
            gen = $urandom_range(0, MODN - 1);
            samp(gen, d);
         end else begin
            gen = (gen + (d ? MODN - 1 : 1)) % MODN;
            samp(gen, d);
         end
      end

      // Drive the error counter to saturation.
      for (int i = 0; i < 270; i++) begin
         a = $urandom_range(0, MODN - 1);
         samp(a, DIR_UP); samp(a + 1, DIR_UP); samp(a + 2, DIR_UP); samp(a + 3, DIR_UP);
         samp(a + 11, DIR_UP);
      end
      chk("lit_err_saturated", int'(err_count), ERR_MAX);
      chk("lit_pulse_at_sat", int'(err_pulse), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
